nanorv32_mem_arb: RTL and testbench

Two-to-one memory arbiter for the nanorv32 core. It shares one unified memory port between the CPU code-fetch interface (`cpu_codemem_*`) and data-access interface (`cpu_datamem_*`). Each transfer is registered, valid/ready handshaked and carried to completion. Data accesses have priority, and a bounded burst counter guarantees forward progress for instruction fetch.

---
 rtl/nanorv32_mem_arb_if.sv | 50 +++++
 rtl/nanorv32_mem_arb.sv | 100 ++++++++++
 tb/tb_nanorv32_mem_arb.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_mem_arb_if.sv
// rtl/nanorv32_mem_arb_if.sv - code/data requester and unified memory port bundle for the arbiter
interface nanorv32_mem_arb_if #(
  parameter int ADDR_MSB = 31,
  parameter int DATA_MSB = 31
);
  logic [ADDR_MSB:0] cpu_codemem_addr;
  logic              cpu_codemem_valid;
  logic [DATA_MSB:0] codemem_cpu_rdata;
  logic              codemem_cpu_ready;

  logic [ADDR_MSB:0] cpu_datamem_addr;
  logic [DATA_MSB:0] cpu_datamem_wdata;
  logic [3:0]        cpu_datamem_bytesel;
  logic              cpu_datamem_write;
  logic              cpu_datamem_valid;
  logic [DATA_MSB:0] datamem_cpu_rdata;
  logic              datamem_cpu_ready;

  logic [ADDR_MSB:0] mem_addr;
  logic [DATA_MSB:0] mem_wdata;
  logic [3:0]        mem_bytesel;
  logic              mem_write;
  logic              mem_valid;
  logic [DATA_MSB:0] mem_rdata;
  logic              mem_ready;

  logic [1:0]        arb_grant;

  modport slave (
    input  cpu_codemem_addr, cpu_codemem_valid,
    input  cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel,
    input  cpu_datamem_write, cpu_datamem_valid,
    input  mem_rdata, mem_ready,
    output codemem_cpu_rdata, codemem_cpu_ready,
    output datamem_cpu_rdata, datamem_cpu_ready,
    output mem_addr, mem_wdata, mem_bytesel, mem_write, mem_valid,
    output arb_grant
  );

  modport master (
    output cpu_codemem_addr, cpu_codemem_valid,
    output cpu_datamem_addr, cpu_datamem_wdata, cpu_datamem_bytesel,
    output cpu_datamem_write, cpu_datamem_valid,
    output mem_rdata, mem_ready,
    input  codemem_cpu_rdata, codemem_cpu_ready,
    input  datamem_cpu_rdata, datamem_cpu_ready,
    input  mem_addr, mem_wdata, mem_bytesel, mem_write, mem_valid,
    input  arb_grant
  );
endinterface

// File: rtl/nanorv32_mem_arb.sv
// rtl/nanorv32_mem_arb.sv - two-to-one code/data memory arbiter with data priority and fetch starvation guard
module nanorv32_mem_arb #(
  parameter int NRV32_ADDR_MSB = 31,
  parameter int NRV32_DATA_MSB = 31,
  parameter int MAX_DATA_BURST = 4
) (
  input logic               clk,
  input logic               rst,
  nanorv32_mem_arb_if.slave bus
);
  localparam logic [3:0] MAX_BURST = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CODE = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_streak;
  logic [NRV32_ADDR_MSB:0] r_mem_addr;
  logic [NRV32_DATA_MSB:0] r_mem_wdata;
  logic [3:0]            r_mem_bytesel;
  logic                  r_mem_write;
  logic                  r_mem_valid;
  logic [1:0]            r_arb_grant;

  logic w_take_data;
  logic w_take_code;

  // Data wins unless a fetch has already waited out a full data burst.
  assign w_take_data = bus.cpu_datamem_valid &&
                       (!bus.cpu_codemem_valid || (r_streak < MAX_BURST));
  assign w_take_code = bus.cpu_codemem_valid && !w_take_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_streak      <= 4'd0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_bytesel <= 4'd0;
      r_mem_write   <= 1'b0;
      r_mem_valid   <= 1'b0;
      r_arb_grant   <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_data) begin
            r_state       <= S_DATA;
            r_mem_addr    <= bus.cpu_datamem_addr;
            r_mem_wdata   <= bus.cpu_datamem_wdata;
            r_mem_bytesel <= bus.cpu_datamem_bytesel;
            r_mem_write   <= bus.cpu_datamem_write;
            r_mem_valid   <= 1'b1;
            r_arb_grant   <= 2'b10;
            if (!bus.cpu_codemem_valid)
              r_streak <= 4'd0;
            else if (r_streak != MAX_BURST)
              r_streak <= r_streak + 4'd1;
          end else if (w_take_code) begin
            r_state       <= S_CODE;
            r_mem_addr    <= bus.cpu_codemem_addr;
            r_mem_wdata   <= '0;
            r_mem_bytesel <= 4'b1111;
            r_mem_write   <= 1'b0;
            r_mem_valid   <= 1'b1;
            r_arb_grant   <= 2'b01;
            r_streak      <= 4'd0;
          end
        end
        S_CODE, S_DATA: begin
          if (bus.mem_ready) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_arb_grant <= 2'b00;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_valid <= 1'b0;
          r_arb_grant <= 2'b00;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.mem_bytesel = r_mem_bytesel;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_valid   = r_mem_valid;
  assign bus.arb_grant   = r_arb_grant;

  // Completion is reported in the same cycle the memory acknowledges.
  assign bus.codemem_cpu_ready = bus.mem_ready && (r_state == S_CODE);
  assign bus.datamem_cpu_ready = bus.mem_ready && (r_state == S_DATA);
  assign bus.codemem_cpu_rdata = bus.mem_rdata;
  assign bus.datamem_cpu_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_nanorv32_mem_arb.sv
// tb/tb_nanorv32_mem_arb.sv - self-checking bench for nanorv32_mem_arb
module tb_nanorv32_mem_arb;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  nanorv32_mem_arb_if #(.ADDR_MSB(31), .DATA_MSB(31)) bus();

  nanorv32_mem_arb #(
    .NRV32_ADDR_MSB(31),
    .NRV32_DATA_MSB(31),
    .MAX_DATA_BURST(4)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic drive_idle;
    bus.cpu_codemem_addr    = '0;
    bus.cpu_codemem_valid   = 1'b0;
    bus.cpu_datamem_addr    = '0;
    bus.cpu_datamem_wdata   = '0;
    bus.cpu_datamem_bytesel = 4'd0;
    bus.cpu_datamem_write   = 1'b0;
    bus.cpu_datamem_valid   = 1'b0;
    bus.mem_rdata           = '0;
    bus.mem_ready           = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive_idle();
    tick();
    @(negedge clk);
    total++;
    if ({bus.mem_valid, bus.arb_grant, bus.mem_write, bus.mem_bytesel,
         bus.codemem_cpu_ready, bus.datamem_cpu_ready} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {bus.mem_valid, bus.arb_grant, bus.mem_write,
               bus.mem_bytesel, bus.codemem_cpu_ready, bus.datamem_cpu_ready});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'd0) begin
      bad++;
      $display("FAIL reset_payload got=%h exp=0", {bus.mem_addr, bus.mem_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch;
    do_reset();
    bus.cpu_codemem_valid = 1'b1;
    bus.cpu_codemem_addr  = 32'h100;
    bus.mem_ready         = 1'b1;
    bus.mem_rdata         = 32'h0000_0013;
    @(negedge clk);
    total++;
    if ({bus.codemem_cpu_ready, bus.arb_grant} !== 3'b000) begin
      bad++;
      $display("FAIL fetch_pre_grant got=%b exp=000", {bus.codemem_cpu_ready, bus.arb_grant});
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_bytesel, bus.mem_write, bus.arb_grant} !==
        {1'b1, 32'h100, 4'b1111, 1'b0, 2'b01}) begin
      bad++;
      $display("FAIL fetch_mem got=%h exp=%h",
               {bus.mem_valid, bus.mem_addr, bus.mem_bytesel, bus.mem_write, bus.arb_grant},
               {1'b1, 32'h100, 4'b1111, 1'b0, 2'b01});
    end
    total++;
    if ({bus.codemem_cpu_ready, bus.datamem_cpu_ready, bus.codemem_cpu_rdata} !==
        {2'b10, 32'h0000_0013}) begin
      bad++;
      $display("FAIL fetch_ready got=%h exp=%h",
               {bus.codemem_cpu_ready, bus.datamem_cpu_ready, bus.codemem_cpu_rdata},
               {2'b10, 32'h0000_0013});
    end
    tick();
    bus.cpu_codemem_valid = 1'b0;
    bus.mem_ready         = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.mem_valid, bus.arb_grant, bus.codemem_cpu_ready} !== 4'b0) begin
      bad++;
      $display("FAIL fetch_release got=%b exp=0000",
               {bus.mem_valid, bus.arb_grant, bus.codemem_cpu_ready});
    end
  endtask

  task automatic test_data_write;
    int pulses = 0;
    do_reset();
    bus.cpu_datamem_valid   = 1'b1;
    bus.cpu_datamem_addr    = 32'h2000;
    bus.cpu_datamem_wdata   = 32'hDEAD_BEEF;
    bus.cpu_datamem_bytesel = 4'b0011;
    bus.cpu_datamem_write   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_ready = (i == 3);
      @(negedge clk);
      total++;
      if ({bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_bytesel, bus.mem_write,
           bus.arb_grant} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 2'b10}) begin
        bad++;
        $display("FAIL write_stable cyc=%0d got=%h exp=%h", i,
                 {bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_bytesel, bus.mem_write,
                  bus.arb_grant}, {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 2'b10});
      end
      if (bus.datamem_cpu_ready === 1'b1) pulses++;
      total++;
      if ({bus.datamem_cpu_ready, bus.codemem_cpu_ready} !== {(i == 3), 1'b0}) begin
        bad++;
        $display("FAIL write_ready cyc=%0d got=%b exp=%b", i,
                 {bus.datamem_cpu_ready, bus.codemem_cpu_ready}, {(i == 3), 1'b0});
      end
    end
    tick();
    bus.cpu_datamem_valid = 1'b0;
    bus.mem_ready         = 1'b0;
    @(negedge clk);
    total++;
    if (pulses != 1 || bus.arb_grant !== 2'b00) begin
      bad++;
      $display("FAIL write_done pulses=%0d grant=%b exp pulses=1 grant=00", pulses, bus.arb_grant);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    bus.mem_ready         = 1'b1;
    bus.cpu_codemem_valid = 1'b1;
    bus.cpu_codemem_addr  = 32'h400;
    bus.cpu_datamem_valid = 1'b1;
    bus.cpu_datamem_addr  = 32'h800;
    bus.cpu_datamem_bytesel = 4'b1111;
    tick();
    @(negedge clk);
    total++;
    if ({bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL simul_first got=%b exp=1010",
               {bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready});
    end
    tick();
    bus.cpu_datamem_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL simul_bubble got=%b exp=0000",
               {bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready});
    end
    tick();
    @(negedge clk);
    total++;
    if ({bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready, bus.mem_addr} !==
        {4'b0101, 32'h400}) begin
      bad++;
      $display("FAIL simul_code got=%h exp=%h",
               {bus.arb_grant, bus.datamem_cpu_ready, bus.codemem_cpu_ready, bus.mem_addr},
               {4'b0101, 32'h400});
    end
    tick();
    drive_idle();
  endtask

  task automatic test_starvation;
    int seq[$];
    int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
    bit drop = 1'b0;
    do_reset();
    bus.mem_ready           = 1'b1;
    bus.cpu_datamem_valid   = 1'b1;
    bus.cpu_datamem_addr    = 32'h40;
    bus.cpu_datamem_bytesel = 4'b1111;
    bus.cpu_codemem_valid   = 1'b1;
    bus.cpu_codemem_addr    = 32'h80;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (drop) bus.cpu_codemem_valid = 1'b0;
      @(negedge clk);
      if (bus.arb_grant === 2'b10) seq.push_back(2);
      if (bus.arb_grant === 2'b01) seq.push_back(1);
      drop = bus.codemem_cpu_ready;
    end
    total++;
    if (seq.size() < 6) begin
      bad++;
      $display("FAIL starve_count got=%0d exp>=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (seq[i] != exp_seq[i]) begin
          bad++;
          $display("FAIL starve_seq idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]);
        end
      end
    end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.cpu_datamem_valid   = 1'b1;
    bus.cpu_datamem_addr    = 32'h3000;
    bus.cpu_datamem_bytesel = 4'b1111;
    bus.cpu_datamem_write   = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if ({bus.mem_valid, bus.arb_grant} !== 3'b110) begin
      bad++;
      $display("FAIL mid_grant got=%b exp=110", {bus.mem_valid, bus.arb_grant});
    end
    tick();
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    total++;
    if ({bus.mem_valid, bus.arb_grant, bus.datamem_cpu_ready} !== 4'b0000) begin
      bad++;
      $display("FAIL mid_async got=%b exp=0000",
               {bus.mem_valid, bus.arb_grant, bus.datamem_cpu_ready});
    end
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_datamem_valid = 1'b0;
    bus.cpu_codemem_valid = 1'b1;
    bus.cpu_codemem_addr  = 32'h200;
    tick();
    @(negedge clk);
    total++;
    if ({bus.arb_grant, bus.codemem_cpu_ready, bus.datamem_cpu_ready, bus.mem_addr} !==
        {4'b0110, 32'h200}) begin
      bad++;
      $display("FAIL mid_refetch got=%h exp=%h",
               {bus.arb_grant, bus.codemem_cpu_ready, bus.datamem_cpu_ready, bus.mem_addr},
               {4'b0110, 32'h200});
    end
    tick();
    drive_idle();
  endtask

  task automatic test_spurious_idle;
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total++;
      if ({bus.mem_valid, bus.arb_grant, bus.codemem_cpu_ready, bus.datamem_cpu_ready} !== 5'b0) begin
        bad++;
        $display("FAIL spurious cyc=%0d got=%b exp=00000", i,
                 {bus.mem_valid, bus.arb_grant, bus.codemem_cpu_ready, bus.datamem_cpu_ready});
      end
    end
    drive_idle();
  endtask

  // Transaction-level reference: who owns the port, what it asked for, and the fairness count.
  task automatic test_random;
    int          owner = 0;
    int          streak = 0;
    int          n_code = 0;
    int          n_data = 0;
    bit          c_done = 1'b0;
    bit          d_done = 1'b0;
    logic [31:0] e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic [3:0]  e_bsel = '0;
    logic        e_write = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (c_done || (!bus.cpu_codemem_valid && ($urandom % 3) == 0)) begin
        bus.cpu_codemem_valid = c_done ? (($urandom % 2) == 1) : 1'b1;
        bus.cpu_codemem_addr  = $urandom & 32'hFFFF_FFFC;
      end
      if (d_done || (!bus.cpu_datamem_valid && ($urandom % 3) == 0)) begin
        bus.cpu_datamem_valid   = d_done ? (($urandom % 2) == 1) : 1'b1;
        bus.cpu_datamem_addr    = $urandom;
        bus.cpu_datamem_wdata   = $urandom;
        bus.cpu_datamem_bytesel = 4'($urandom % 16);
        bus.cpu_datamem_write   = (($urandom % 2) == 1);
      end
      bus.mem_ready = (($urandom % 3) == 0);
      bus.mem_rdata = $urandom;
      @(negedge clk);
      total++;
      if ({bus.mem_valid, bus.arb_grant} !== {owner != 0, owner == 2, owner == 1}) begin
        bad++;
        $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, {bus.mem_valid, bus.arb_grant},
                 {owner != 0, owner == 2, owner == 1});
      end
      if (owner != 0) begin
        total++;
        if ({bus.mem_addr, bus.mem_bytesel, bus.mem_write} !== {e_addr, e_bsel, e_write}) begin
          bad++;
          $display("FAIL rnd_payload cyc=%0d got=%h exp=%h", cyc,
                   {bus.mem_addr, bus.mem_bytesel, bus.mem_write}, {e_addr, e_bsel, e_write});
        end
      end
      if (owner == 2) begin
        total++;
        if (bus.mem_wdata !== e_wdata) begin
          bad++;
          $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, bus.mem_wdata, e_wdata);
        end
      end
      c_done = (owner == 1) && bus.mem_ready;
      d_done = (owner == 2) && bus.mem_ready;
      total++;
      if ({bus.codemem_cpu_ready, bus.datamem_cpu_ready} !== {c_done, d_done}) begin
        bad++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc,
                 {bus.codemem_cpu_ready, bus.datamem_cpu_ready}, {c_done, d_done});
      end
      if (c_done) begin
        n_code++;
        total++;
        if (bus.codemem_cpu_rdata !== bus.mem_rdata) begin
          bad++;
          $display("FAIL rnd_code_rdata cyc=%0d got=%h exp=%h", cyc, bus.codemem_cpu_rdata, bus.mem_rdata);
        end
      end
      if (d_done) begin
        n_data++;
        total++;
        if (bus.datamem_cpu_rdata !== bus.mem_rdata) begin
          bad++;
          $display("FAIL rnd_data_rdata cyc=%0d got=%h exp=%h", cyc, bus.datamem_cpu_rdata, bus.mem_rdata);
        end
      end
      if (owner == 0) begin
        if (bus.cpu_datamem_valid && (!bus.cpu_codemem_valid || streak < 4)) begin
          owner   = 2;
          streak  = bus.cpu_codemem_valid ? ((streak < 4) ? streak + 1 : 4) : 0;
          e_addr  = bus.cpu_datamem_addr;
          e_wdata = bus.cpu_datamem_wdata;
          e_bsel  = bus.cpu_datamem_bytesel;
          e_write = bus.cpu_datamem_write;
        end else if (bus.cpu_codemem_valid) begin
          owner   = 1;
          streak  = 0;
          e_addr  = bus.cpu_codemem_addr;
          e_bsel  = 4'b1111;
          e_write = 1'b0;
        end
      end else if (bus.mem_ready) begin
        owner = 0;
      end
      tick();
    end
    total++;
    if (n_code == 0 || n_data == 0) begin
      bad++;
      $display("FAIL rnd_progress code=%0d data=%0d exp both >0", n_code, n_data);
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_spurious_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
